// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: drives per-stage PAUSE/FLUSH for load-use,
// taken-jump and instruction-SRAM structural hazards, plus a stall counter.
module hazard_ctrl #(
   parameter int unsigned MEM_WAIT  = 1,
   parameter logic [15:0] DATA_BASE = 16'h8000
) (
   input  logic        clk_50MHz,
   input  logic        rst,
   input  logic [3:0]  id_SRC_A_ADDR,
   input  logic        id_SRC_A_USE,
   input  logic [3:0]  id_SRC_B_ADDR,
   input  logic        id_SRC_B_USE,
   input  logic        ie_RAM_en,
   input  logic        ie_RAM_op,
   input  logic [3:0]  ie_DEST_ADDR,
   input  logic        ie_DEST_EN,
   input  logic        ie_JUMP_TAKEN,
   input  logic        em_RAM_en,
   input  logic [15:0] em_RAM_ADDR,
   output logic        pc_PAUSE,
   output logic        ii_PAUSE,
   output logic        ie_PAUSE,
   output logic        em_PAUSE,
   output logic        ii_FLUSH,
   output logic        ie_FLUSH,
   output logic        stall_busy,
   output logic [15:0] stall_cnt
);

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_STRUCT = 1'b1;
   localparam logic [3:0] MW        = 4'(MEM_WAIT);
   localparam logic [3:0] MW_M1     = MW - 4'd1;

   logic [0:0]  st_q, st_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic lu, sc, freeze, rel;
   logic pc_p, ii_p, ie_p, em_p, ii_f, ie_f;

   assign lu = ie_RAM_en & ~ie_RAM_op & ie_DEST_EN &
               ((id_SRC_A_USE & (id_SRC_A_ADDR == ie_DEST_ADDR)) |
                (id_SRC_B_USE & (id_SRC_B_ADDR == ie_DEST_ADDR)));
   assign sc = em_RAM_en & (em_RAM_ADDR < DATA_BASE);

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      freeze = 1'b0;
      rel    = 1'b0;
      pc_p   = 1'b0;
      ii_p   = 1'b0;
      ie_p   = 1'b0;
      em_p   = 1'b0;
      ii_f   = 1'b0;
      ie_f   = 1'b0;
      case (st_q)
         ST_RUN: begin
            if (sc && (MW != 4'd0)) begin
               freeze = 1'b1;
               cnt_d  = MW_M1;
               st_d   = ST_STRUCT;
            end else if (sc) begin
               rel = 1'b1;
            end else if (ie_JUMP_TAKEN) begin
               ii_f = 1'b1;
               ie_f = 1'b1;
            end else if (lu) begin
               pc_p = 1'b1;
               ii_p = 1'b1;
               ie_f = 1'b1;
            end
         end
         default: begin
            // Frozen pipeline: jump and load-use inputs are stale, so ignore them.
            if (cnt_q != 4'd0) begin
               freeze = 1'b1;
               cnt_d  = cnt_q - 4'd1;
            end else begin
               rel  = 1'b1;
               st_d = ST_RUN;
            end
         end
      endcase
      if (freeze) begin
         pc_p = 1'b1;
         ii_p = 1'b1;
         ie_p = 1'b1;
         em_p = 1'b1;
      end
      // Release: IF fetched nothing, so a bubble enters IF/ID unless redirected or held.
      if (rel) begin
         pc_p = 1'b1;
         ii_f = 1'b1;
         if (ie_JUMP_TAKEN) begin
            pc_p = 1'b0;
            ie_f = 1'b1;
         end else if (lu) begin
            ii_p = 1'b1;
            ii_f = 1'b0;
            ie_f = 1'b1;
         end
      end
   end

   assign pc_PAUSE   = rst & pc_p;
   assign ii_PAUSE   = rst & ii_p;
   assign ie_PAUSE   = rst & ie_p;
   assign em_PAUSE   = rst & em_p;
   assign ii_FLUSH   = rst & ii_f;
   assign ie_FLUSH   = rst & ie_f;
   assign stall_busy = rst & (st_q == ST_STRUCT);
   assign stall_cnt  = stall_cnt_q;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (pc_PAUSE && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(posedge clk_50MHz or negedge rst) begin
      if (!rst) begin
         st_q        <= ST_RUN;
         cnt_q       <= 4'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
